shift_window_seq: RTL
=====================

// Module: shift_window_seq
// PURPOSE
//  Sequencer for the 8-entry shift_8_multi_read buffer in the edge-detector pixel path.
//  - Accepts a 32-bit pixel stream (valid/ready) and writes each pixel at a circular write pointer.
//  - Gathers the newest TAPS samples serially through the buffer's registered rd_data port.
//  - Presents them as one packed window (valid/ready) to the filter stage.
//  - The buffer's combinational tap outputs p2..p7 are left unconnected; every tap comes through rd_data.
// PARAMETERS
//  DEPTH   8   buffer entries; power of two, 2..128; pointer width log2(DEPTH)
//  TAPS    7   samples per window; 2..DEPTH
//  DATA_W  32  pixel width; must match the buffer
// PORTS
//  clk          in   1             clock, all logic on posedge
//  rst          in   1             synchronous reset, active-high
//  in_valid     in   1             pixel offered
//  in_ready     out  1             = (state==IDLE) && !rst
//  in_data      in   DATA_W        pixel
//  line_start   in   1             sampled with accepted pixel; restarts history
//  buf_write_en out  1             to buffer write_en
//  buf_addr     out  7             to buffer addr; bits above the pointer width always 0
//  buf_wr_data  out  DATA_W        to buffer wr_data
//  buf_rd_data  in   DATA_W        from buffer rd_data; 1-cycle registered read
//  win_valid    out  1             window held
//  win_ready    in   1             downstream accepts window
//  win_data     out  TAPS*DATA_W   tap k in bits [k*DATA_W +: DATA_W]; tap0 = newest
//  fill_count   out  8             valid history depth, saturates at TAPS
// BEHAVIOUR
//  - Reset values (next edge after rst=1):
//    - state=IDLE, wptr=0, fill_count=0, win_valid=0, win_data=0
//    - buf_write_en=0, buf_addr=0, buf_wr_data=0
//  - All outputs are registered except in_ready.
//  - States and transitions:
//    - IDLE: in_valid&&in_ready -> register in_data into buf_wr_data.
//      fill_count <= line_start ? 1 : min(fill_count+1, TAPS). Go to WRITE.
//    - WRITE (1 cycle): buf_write_en=1, buf_addr=wptr. Never read in this cycle.
//      Leaving WRITE: buf_write_en=0. If window emitted: k=0, go to READ; else go to DONE.
//      Window emitted when fill_count==TAPS.
//    - READ (TAPS cycles): buf_addr=(wptr-k) mod DEPTH, k=0..TAPS-1.
//      Capture buf_rd_data into tap k-1 when k>=1. Last cycle goes to DRAIN.
//    - DRAIN (1 cycle): capture tap TAPS-1. Set win_valid=1. Go to OUT.
//    - OUT: hold win_valid and win_data stable until win_ready; then win_valid=0, go to DONE.
//    - DONE (1 cycle): wptr <= (wptr+1) mod DEPTH. Go to IDLE.
//  - Latency (default TAPS=7):
//    - Accept at cycle 0 -> WRITE cycle 1, READ cycles 2..8, DRAIN cycle 9.
//    - win_valid=1 from cycle 10.
//    - With win_ready=1 at cycle 10: DONE at cycle 11, in_ready=1 at cycle 12. 12 cycles/pixel.
//    - Pixel that emits no window: in_ready returns at cycle 3.
//  - Boundary conditions:
//    - Wrap: wptr DEPTH-1 -> 0; tap addresses computed mod DEPTH, never out of range.
//    - line_start: history restarts at the current pixel; wptr continues unchanged.
//    - win_ready before win_valid: ignored.
//    - in_valid outside IDLE: not accepted, no effect.
//    - rst in any state: abort; no window emitted, history discarded (fill_count=0).
// CONFIGURATION
//  SHIFT_CTRL_ZERO_PAD_EN
//  - Defined: every accepted pixel emits a window.
//    Taps k >= fill_count are forced to 0; their capture is replaced by 0, READ timing unchanged.
//  - Undefined: windows only when fill_count==TAPS.
// TESTING
//  1. rst, then pixels 1..7, win_ready=1 -> windows only after the 7th pixel.
//     Taps {7,6,5,4,3,2,1}; win_valid 10 cycles after acceptance.
//  2. Continue with pixels 8,9,10 -> windows {8..2},{9..3},{10..4}.
//     wptr wraps 7->0 on pixel 9; taps stay correct across the wrap.
//  3. Full history, win_ready=0 for 5 cycles -> win_valid=1 and win_data stable.
//     in_ready=0, buf_write_en=0 throughout.
//  4. Full history, pixel 0x100 with line_start=1 -> fill_count=1, no window.
//     Next window after 6 more pixels, tap6=0x100.
//  5. rst pulsed during READ -> win_valid=0 and state IDLE after the edge.
//     fill_count=0; 7 new pixels required before any window.
//  6. SHIFT_CTRL_ZERO_PAD_EN defined, first pixel 0xA after rst -> window {0xA,0,0,0,0,0,0} at cycle 10.

Source files
------------

// File: rtl/shift_window_seq.sv
// shift_window_seq: pixel write and serial tap-gather sequencer for the 8-entry shift buffer.
// Build option SHIFT_CTRL_ZERO_PAD_EN: emit a zero-padded window for every accepted pixel.
module shift_window_seq #(
  parameter int DEPTH  = 8,
  parameter int TAPS   = 7,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   line_start,
  output logic                   buf_write_en,
  output logic [6:0]             buf_addr,
  output logic [DATA_W-1:0]      buf_wr_data,
  input  logic [DATA_W-1:0]      buf_rd_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [TAPS*DATA_W-1:0] win_data,
  output logic [7:0]             fill_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(TAPS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    OUT,
    DONE
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_wptr;
  logic [KW-1:0]           r_k;
  logic [7:0]              r_fill;
  logic                    r_win_valid;
  logic [TAPS*DATA_W-1:0]  r_win_data;
  logic                    r_wen;
  logic [6:0]              r_addr;
  logic [DATA_W-1:0]       r_wr_data;

  logic [7:0]              w_fill_inc;
  logic                    w_emit;
  logic                    w_last;
  logic [PW-1:0]           w_rd_ptr;
  logic [7:0]              w_tap_idx;
  logic                    w_cap_en;
  logic                    w_tap_ok;
  logic [DATA_W-1:0]       w_cap;

  assign in_ready     = (r_state == IDLE) && !rst;
  assign buf_write_en = r_wen;
  assign buf_addr     = r_addr;
  assign buf_wr_data  = r_wr_data;
  assign win_valid    = r_win_valid;
  assign win_data     = r_win_data;
  assign fill_count   = r_fill;

  assign w_fill_inc = (r_fill >= 8'(TAPS - 1)) ? 8'(TAPS) : r_fill + 8'd1;
  assign w_last     = (r_k == KW'(TAPS - 1));
  assign w_rd_ptr   = r_wptr - PW'(r_k + KW'(1));

  // rd_data lags the address by one cycle, so READ step k lands tap k-1
  assign w_tap_idx = (r_state == DRAIN) ? 8'(TAPS - 1)
                                        : 8'(r_k) - 8'd1;
  assign w_cap_en  = ((r_state == READ) && (r_k != '0)) ||
                     (r_state == DRAIN);

`ifdef SHIFT_CTRL_ZERO_PAD_EN
  assign w_emit   = 1'b1;
  assign w_tap_ok = (w_tap_idx < r_fill);
`else
  assign w_emit   = (r_fill == 8'(TAPS));
  assign w_tap_ok = 1'b1;
`endif

  assign w_cap = w_tap_ok ? buf_rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_k         <= '0;
      r_fill      <= '0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
    end else begin
      if (w_cap_en) begin
        for (int t = 0; t < TAPS; t++) begin
          if (w_tap_idx == 8'(t))
            r_win_data[t*DATA_W +: DATA_W] <= w_cap;
        end
      end
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_wr_data <= in_data;
            r_fill    <= line_start ? 8'd1 : w_fill_inc;
            r_wen     <= 1'b1;
            r_addr    <= 7'(r_wptr);
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          r_wen <= 1'b0;
          r_k   <= '0;
          if (w_emit) begin
            r_addr  <= 7'(r_wptr);
            r_state <= READ;
          end else begin
            r_state <= DONE;
          end
        end
        READ: begin
          if (w_last) begin
            r_state <= DRAIN;
          end else begin
            r_k    <= r_k + KW'(1);
            r_addr <= 7'(w_rd_ptr);
          end
        end
        DRAIN: begin
          r_win_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (win_ready) begin
            r_win_valid <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_wptr  <= r_wptr + PW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
